// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder: the transfer Type encodings
// seen on the MOV/MOC bus, the responder FSM states and the byte-address
// width.
// Configuration macro used by the files that import this package:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned or reserved-type requests
//                       complete with Err = 1 and have no side effect.
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int MEM_ADDR_W = 9;

   typedef enum logic [1:0] {
      TYPE_BYTE = 2'b00,
      TYPE_HALF = 2'b01,
      TYPE_WORD = 2'b10,
      TYPE_RSVD = 2'b11
   } type_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// MEM_BYTES x 8 storage with four byte lanes and big-endian lane steering.
// Lane i addresses byte (base + i) and carries data bits [31-8i -: 8], so the
// byte at the base address always sits in the most significant lane.
// Addresses wrap modulo MEM_BYTES (a power of two).
// Ports:
//   Clk      in   rising-edge clock (writes only; reads are combinational)
//   base     in   byte address of lane 0
//   lane_en  in   per-lane write enable, bit 3 = lane 0 (byte at base)
//   wr_data  in   write data, lane 0 in [31:24]
//   rd_data  out  read data, lane 0 in [31:24]
// -----------------------------------------------------------------------------
module mem_byte_array
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 512
)(
   input  logic                  Clk,
   input  logic [MEM_ADDR_W-1:0] base,
   input  logic [3:0]            lane_en,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data
);

   localparam int IDX_W = $clog2(MEM_BYTES);

   logic [7:0]       mem [MEM_BYTES];
   logic [IDX_W-1:0] idx [4];

   // Truncating the sum to IDX_W bits gives the modulo-MEM_BYTES wrap.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         idx[i] = IDX_W'(base + MEM_ADDR_W'(i));
      end
   end

   // NOTE: the storage has no reset branch; clearing a RAM costs a cycle per
   // word or a huge reset fan-out, and software never relies on its contents.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_en[3-i]) begin
            mem[idx[i]] <= wr_data[31-8*i -: 8];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 4; i++) begin
         rd_data[31-8*i -: 8] = mem[idx[i]];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory side of the MOV/MOC four-phase handshake. A request is captured from
// IDLE, waits WAIT_CYCLES edges in BUSY, performs the access on the following
// edge and raises MOC, then holds MOC in DONE until MOV falls.
// Parameters:
//   WAIT_CYCLES  wait states before completion, legal range 0..15
//   MEM_BYTES    array depth in bytes (power of two, default 512)
// Ports:
//   Clk      in   rising-edge clock
//   Clr_n    in   asynchronous active-low reset
//   MOV      in   memory operation valid
//   RW       in   1 = read, 0 = write
//   Type     in   00 byte, 01 halfword, 10 word, 11 reserved
//   Addr     in   byte address
//   DataIn   in   right-justified write data
//   DataOut  out  right-justified, zero-extended read data of the last good read
//   MOC      out  memory operation complete
//   Err      out  the completion carried an alignment/type error
// Configuration: MEM_ALIGN_CHECK_EN enables error reporting; without it,
// halfword/word addresses are force-aligned and Type 11 acts as a word.
// -----------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_BYTES   = 512
)(
   input  logic                  Clk,
   input  logic                  Clr_n,
   input  logic                  MOV,
   input  logic                  RW,
   input  logic [1:0]            Type,
   input  logic [MEM_ADDR_W-1:0] Addr,
   input  logic [31:0]           DataIn,
   output logic [31:0]           DataOut,
   output logic                  MOC,
   output logic                  Err
);

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  capture, complete;

   logic                  req_rw;
   type_t                 req_type;
   logic [MEM_ADDR_W-1:0] req_addr;
   logic [31:0]           req_data;

   logic                  req_err;
   logic [MEM_ADDR_W-1:0] eff_addr;
   logic [3:0]            size_lanes;
   logic [3:0]            lane_en;
   logic [31:0]           wr_lanes, rd_lanes, rd_ext;

   // Request decode: alignment handling, lane mask and data justification.
   // NOTE: every signal assigned in a combinational block gets a default at
   // the top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      eff_addr   = req_addr;
      req_err    = 1'b0;
      size_lanes = 4'b1111;
      wr_lanes   = req_data;
      rd_ext     = rd_lanes;
`ifdef MEM_ALIGN_CHECK_EN
      case (req_type)
         TYPE_HALF: req_err = req_addr[0];
         TYPE_WORD: req_err = |req_addr[1:0];
         TYPE_RSVD: req_err = 1'b1;
         default:   req_err = 1'b0;
      endcase
`else
      case (req_type)
         TYPE_BYTE: eff_addr      = req_addr;
         TYPE_HALF: eff_addr[0]   = 1'b0;
         default:   eff_addr[1:0] = 2'b00;   // word and reserved
      endcase
`endif
      case (req_type)
         TYPE_BYTE: begin
            size_lanes = 4'b1000;
            wr_lanes   = {req_data[7:0], 24'h0};
            rd_ext     = {24'h0, rd_lanes[31:24]};
         end
         TYPE_HALF: begin
            size_lanes = 4'b1100;
            wr_lanes   = {req_data[15:0], 16'h0};
            rd_ext     = {16'h0, rd_lanes[31:16]};
         end
         default: begin
            size_lanes = 4'b1111;
            wr_lanes   = req_data;
            rd_ext     = rd_lanes;
         end
      endcase
   end

   // Writes commit only on the completion edge, so an aborted transfer
   // leaves the array untouched.
   assign lane_en = (complete && !req_rw && !req_err) ? size_lanes : 4'b0000;

   mem_byte_array #(
      .MEM_BYTES (MEM_BYTES)
   ) u_array (
      .Clk     (Clk),
      .base    (eff_addr),
      .lane_en (lane_en),
      .wr_data (wr_lanes),
      .rd_data (rd_lanes)
   );

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (MOV) begin
               capture   = 1'b1;
               cnt_nxt   = 4'(WAIT_CYCLES);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               complete  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (!MOV) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all sequential state is updated with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         DataOut  <= 32'h0;
         req_rw   <= 1'b0;
         req_type <= TYPE_BYTE;
         req_addr <= '0;
         req_data <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) begin
            req_rw   <= RW;
            req_type <= type_t'(Type);
            req_addr <= Addr;
            req_data <= DataIn;
         end
         if (complete && req_rw && !req_err) begin
            DataOut <= rd_ext;
         end
      end
   end

   // DONE is exactly the MOC-high window, and the request registers are
   // stable there, so both flags clear asynchronously with the state.
   assign MOC = (state == DONE);
   assign Err = MOC && req_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder with a byte-array reference model.
// Honours MEM_ALIGN_CHECK_EN the same way the design build does.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int WAIT_CYCLES = 2;
   localparam int MEM_BYTES   = 512;

   logic        Clk = 1'b0;
   logic        Clr_n;
   logic        MOV;
   logic        RW;
   logic [1:0]  Type;
   logic [8:0]  Addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MOC;
   logic        Err;

   always #5 Clk = ~Clk;

   mem_responder #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .MEM_BYTES   (MEM_BYTES)
   ) dut (
      .Clk     (Clk),
      .Clr_n   (Clr_n),
      .MOV     (MOV),
      .RW      (RW),
      .Type    (Type),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .MOC     (MOC),
      .Err     (Err)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] exp_dout;
   logic        last_err;
   logic [31:0] plan_word;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Reference access: big-endian bytes at base..base+size-1, modulo depth.
   task automatic model_access(input logic rw, input logic [1:0] t, input logic [8:0] a,
                               input logic [31:0] d, output logic err, output logic [31:0] rd);
      int size;
      int base;
      size = size_of(t);
      base = int'(a);
      err  = 1'b0;
      rd   = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
      err = (t == 2'b11) || (base % size != 0);
`else
      base = base - (base % size);
`endif
      if (!err) begin
         for (int i = 0; i < size; i++) begin
            int loc;
            loc = (base + i) % MEM_BYTES;
            if (rw) rd = (rd << 8) | 32'(ref_mem[loc]);
            else    ref_mem[loc] = 8'(d >> (8 * (size - 1 - i)));
         end
      end
   endtask

   // One full four-phase transfer. After capture the inputs are scrambled;
   // while MOV is held in DONE they present an aligned write, which must not
   // be captured.
   task automatic xfer(input logic rw, input logic [1:0] t, input logic [8:0] a,
                       input logic [31:0] d, input int hold, input bit drop_early);
      logic        exp_err;
      logic [31:0] rd;
      int          edges;
      model_access(rw, t, a, d, exp_err, rd);
      if (rw && !exp_err) exp_dout = rd;
      @(negedge Clk);
      MOV = 1'b1; RW = rw; Type = t; Addr = a; DataIn = d;
      @(posedge Clk);
      #1;
      RW = 1'($urandom); Type = 2'($urandom); Addr = 9'($urandom); DataIn = $urandom;
      if (drop_early) MOV = 1'b0;
      edges = 0;
      do begin
         @(posedge Clk);
         #1;
         edges++;
      end while (MOC !== 1'b1 && edges < 20);
      last_err = Err;
      check("latency", 32'(edges), 32'(WAIT_CYCLES + 1));
      check("err", 32'(Err), 32'(exp_err));
      check("dout", DataOut, exp_dout);
      if (!drop_early) begin
         RW = 1'b0; Type = 2'b10; Addr = {a[8:2], 2'b00}; DataIn = $urandom;
         for (int h = 0; h < hold; h++) begin
            @(posedge Clk);
            #1;
            check("moc_hold", 32'(MOC), 32'd1);
         end
         @(negedge Clk);
         MOV = 1'b0;
      end
      @(posedge Clk);
      #1;
      check("moc_fall", 32'(MOC), 32'd0);
      check("err_fall", 32'(Err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prior;
      logic        dummy_err;
      MOV = 1'b0; RW = 1'b0; Type = 2'b00; Addr = 9'h0; DataIn = 32'h0;
      Clr_n = 1'b0; exp_dout = 32'h0; last_err = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_moc", 32'(MOC), 32'd0);
      check("reset_err", 32'(Err), 32'd0);
      check("reset_dout", DataOut, 32'h0);
      @(negedge Clk);
      Clr_n = 1'b1;

      // Give every byte a known value.
      for (int a = 0; a < MEM_BYTES; a += 4) begin
         xfer(1'b0, 2'b10, 9'(a), $urandom, 0, 1'b0);
      end

      // Word write then read, byte read of the MSB.
      xfer(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0, 1'b0);
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 0, 1'b0);
      check("plan_word_rd", DataOut, 32'hDEADBEEF);
      xfer(1'b1, 2'b00, 9'h010, 32'h0, 0, 1'b0);
      check("plan_byte_rd", DataOut, 32'h000000DE);

      // Byte write, word and halfword read-back.
      xfer(1'b0, 2'b00, 9'h013, 32'h0000005A, 0, 1'b0);
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 0, 1'b0);
      check("plan_merge_rd", DataOut, 32'hDEADBE5A);
      xfer(1'b1, 2'b01, 9'h012, 32'h0, 0, 1'b0);
      check("plan_half_rd", DataOut, 32'h0000BE5A);

`ifdef MEM_ALIGN_CHECK_EN
      xfer(1'b0, 2'b10, 9'h011, 32'h11111111, 0, 1'b0);
      check("plan_misalign_err", 32'(last_err), 32'd1);
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 0, 1'b0);
      check("plan_misalign_rd", DataOut, 32'hDEADBE5A);
      plan_word = 32'hDEADBE5A;
`else
      xfer(1'b0, 2'b10, 9'h013, 32'hCAFEF00D, 0, 1'b0);
      check("plan_forced_err", 32'(last_err), 32'd0);
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 0, 1'b0);
      check("plan_forced_rd", DataOut, 32'hCAFEF00D);
      plan_word = 32'hCAFEF00D;
`endif

      // MOV held after MOC with a write pending on the bus: no recapture.
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 5, 1'b0);
      xfer(1'b1, 2'b10, 9'h010, 32'h0, 0, 1'b0);
      check("plan_no_recapture", DataOut, plan_word);

      // MOV dropped during BUSY: transfer completes, MOC pulses once.
      xfer(1'b0, 2'b01, 9'h030, 32'h0000A5C3, 0, 1'b1);
      xfer(1'b1, 2'b01, 9'h030, 32'h0, 0, 1'b0);
      check("plan_drop_rd", DataOut, 32'h0000A5C3);

      // Reset asserted at the first wait edge of a word write.
      model_access(1'b1, 2'b10, 9'h020, 32'h0, dummy_err, prior);
      @(negedge Clk);
      MOV = 1'b1; RW = 1'b0; Type = 2'b10; Addr = 9'h020; DataIn = 32'h12345678;
      @(posedge Clk);
      @(posedge Clk);
      #2;
      Clr_n = 1'b0;
      #1;
      check("rst_busy_moc", 32'(MOC), 32'd0);
      check("rst_busy_err", 32'(Err), 32'd0);
      check("rst_busy_dout", DataOut, 32'h0);
      exp_dout = 32'h0;
      MOV = 1'b0;
      @(negedge Clk);
      Clr_n = 1'b1;
      xfer(1'b1, 2'b10, 9'h020, 32'h0, 0, 1'b0);
      check("rst_busy_array", DataOut, prior);

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, MEM_BYTES - 1)),
              $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
